// File: rtl/artemis_ddr3_pkg.sv
// Shared definitions for the Artemis DDR3 port masters: MCB instruction codes,
// burst sizing and the port-master state encoding.
package artemis_ddr3_pkg;

  localparam logic [2:0] MCB_WRITE    = 3'b000;
  localparam logic [2:0] MCB_READ     = 3'b001;
  localparam logic [2:0] MCB_WRITE_AP = 3'b010;
  localparam logic [2:0] MCB_READ_AP  = 3'b011;
  localparam logic [2:0] MCB_REFRESH  = 3'b100;

  localparam int BL_WIDTH  = 6;
  localparam int MAX_BURST = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_FILL,
    ST_WR_CMD,
    ST_RD_CMD,
    ST_RD_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/artemis_ddr3_port_master.sv
// Single-burst user master for one bidirectional MCB port: fills the write FIFO,
// issues the command, and drains the read FIFO as a valid/ready stream.
module artemis_ddr3_port_master
  import artemis_ddr3_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calibration_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [5:0]            req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_be,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [31:0]           rd_data,
  output logic                  done,
  output logic                  err,
  output logic                  err_sticky,
  output logic                  busy,
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [5:0]            cmd_bl,
  output logic [29:0]           cmd_byte_addr,
  input  logic                  cmd_full,
  output logic                  mcb_wr_en,
  output logic [3:0]            mcb_wr_mask,
  output logic [31:0]           mcb_wr_data,
  input  logic                  mcb_wr_full,
  input  logic                  mcb_wr_underrun,
  input  logic                  mcb_wr_error,
  output logic                  mcb_rd_en,
  input  logic [31:0]           mcb_rd_data,
  input  logic                  mcb_rd_empty,
  input  logic                  mcb_rd_overflow,
  input  logic                  mcb_rd_error
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [BL_WIDTH-1:0]   len_reg, len_next;
  logic [BL_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [TMO_W-1:0]      tmo_reg, tmo_next;
  logic                  abort_reg, abort_next;
  logic                  berr_reg, berr_next;
  logic                  sticky_reg, sticky_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  cmd_en_reg, cmd_en_next;
  logic [2:0]            cmd_instr_reg, cmd_instr_next;
  logic [BL_WIDTH-1:0]   cmd_bl_reg, cmd_bl_next;
  logic [29:0]           cmd_addr_reg, cmd_addr_next;
  logic                  status_err;

  assign status_err = mcb_wr_underrun | mcb_wr_error | mcb_rd_overflow | mcb_rd_error;
  assign busy       = (state_reg != ST_IDLE);

  // FIFO-side handshakes are pass-through; data buses read zero outside their phase.
  assign mcb_wr_en   = wr_valid & wr_ready;
  assign mcb_wr_data = (state_reg == ST_WR_FILL) ? wr_data : '0;
  assign mcb_wr_mask = (state_reg == ST_WR_FILL) ? ~wr_be : '0;
  assign mcb_rd_en   = rd_valid & rd_ready;
  assign rd_data     = (state_reg == ST_RD_DRAIN) ? mcb_rd_data : '0;

  assign done          = done_reg;
  assign err           = err_reg;
  assign err_sticky    = sticky_reg;
  assign cmd_en        = cmd_en_reg;
  assign cmd_instr     = cmd_instr_reg;
  assign cmd_bl        = cmd_bl_reg;
  assign cmd_byte_addr = cmd_addr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      tmo_reg       <= '0;
      abort_reg     <= 1'b0;
      berr_reg      <= 1'b0;
      sticky_reg    <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cmd_en_reg    <= 1'b0;
      cmd_instr_reg <= '0;
      cmd_bl_reg    <= '0;
      cmd_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      cnt_reg       <= cnt_next;
      tmo_reg       <= tmo_next;
      abort_reg     <= abort_next;
      berr_reg      <= berr_next;
      sticky_reg    <= sticky_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      cmd_en_reg    <= cmd_en_next;
      cmd_instr_reg <= cmd_instr_next;
      cmd_bl_reg    <= cmd_bl_next;
      cmd_addr_reg  <= cmd_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    cnt_next       = cnt_reg;
    tmo_next       = tmo_reg;
    abort_next     = abort_reg;
    berr_next      = berr_reg;
    sticky_next    = sticky_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    cmd_en_next    = 1'b0;
    cmd_instr_next = cmd_instr_reg;
    cmd_bl_next    = cmd_bl_reg;
    cmd_addr_next  = cmd_addr_reg;
    req_ready      = 1'b0;
    wr_ready       = 1'b0;
    rd_valid       = 1'b0;

    // Status errors are recorded but never interrupt the burst.
    if (busy && status_err) begin
      berr_next   = 1'b1;
      sticky_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        req_ready = calibration_done & rst_n;
        if (req_valid && req_ready) begin
          addr_next  = req_addr;
          len_next   = req_len;
          cnt_next   = '0;
          berr_next  = 1'b0;
          abort_next = 1'b0;
          state_next = req_write ? ST_WR_FILL : ST_RD_CMD;
        end
      end

      ST_WR_FILL: begin
        wr_ready = !mcb_wr_full;
        if (wr_valid && wr_ready) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == len_reg) state_next = ST_WR_CMD;
        end
      end

      ST_WR_CMD, ST_RD_CMD: begin
        if (!cmd_full) begin
          cmd_en_next    = 1'b1;
          cmd_instr_next = (state_reg == ST_WR_CMD) ? MCB_WRITE : MCB_READ;
          cmd_bl_next    = len_reg;
          cmd_addr_next  = 30'({addr_reg, 2'b00});
          cnt_next       = '0;
          tmo_next       = '0;
          state_next     = (state_reg == ST_WR_CMD) ? ST_DONE : ST_RD_DRAIN;
        end
      end

      ST_RD_DRAIN: begin
        rd_valid = !mcb_rd_empty;
        if (rd_valid && rd_ready) begin
          cnt_next = cnt_reg + 1'b1;
          tmo_next = '0;
          if (cnt_reg == len_reg) state_next = ST_DONE;
        end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
          // Abandon the burst; whatever the MCB still holds is left undrained.
          abort_next = 1'b1;
          state_next = ST_DONE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end

      ST_DONE: begin
        done_next  = 1'b1;
        err_next   = abort_reg | berr_reg | status_err;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_artemis_ddr3_port_master.sv
// Scoreboard bench for artemis_ddr3_port_master: a behavioural MCB model answers the
// port, a request-level reference memory predicts every push, command, word and done.
module tb_artemis_ddr3_port_master;
  import artemis_ddr3_pkg::*;

  localparam int AW  = 28;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n, calibration_done;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [5:0]    req_len;
  logic          wr_valid, wr_ready;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          rd_valid, rd_ready = 1'b1;
  logic [31:0]   rd_data;
  logic          done, err, err_sticky, busy;
  logic          cmd_en;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [29:0]   cmd_byte_addr;
  logic          cmd_full = 1'b0;
  logic          mcb_wr_en;
  logic [3:0]    mcb_wr_mask;
  logic [31:0]   mcb_wr_data;
  logic          mcb_wr_full = 1'b0, mcb_wr_underrun, mcb_wr_error;
  logic          mcb_rd_en;
  logic [31:0]   mcb_rd_data = '0;
  logic          mcb_rd_empty = 1'b1, mcb_rd_overflow, mcb_rd_error;

  always #5 clk = ~clk;

  artemis_ddr3_port_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .calibration_done(calibration_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err), .err_sticky(err_sticky), .busy(busy),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .mcb_wr_en(mcb_wr_en), .mcb_wr_mask(mcb_wr_mask), .mcb_wr_data(mcb_wr_data),
    .mcb_wr_full(mcb_wr_full), .mcb_wr_underrun(mcb_wr_underrun),
    .mcb_wr_error(mcb_wr_error),
    .mcb_rd_en(mcb_rd_en), .mcb_rd_data(mcb_rd_data), .mcb_rd_empty(mcb_rd_empty),
    .mcb_rd_overflow(mcb_rd_overflow), .mcb_rd_error(mcb_rd_error)
  );

  logic [127:0] all_outs;
  assign all_outs = {req_ready, wr_ready, rd_valid, rd_data, done, err, err_sticky, busy,
                     cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, mcb_wr_en, mcb_wr_mask,
                     mcb_wr_data, mcb_rd_en};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'h5EED_0000 + 32'(a) * 32'd7;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] ba;
  } cmd_t;

  // Scoreboard queues and request-level reference memory
  cmd_t        exp_cmd[$];
  logic [35:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  bit          exp_done[$];
  logic [31:0] ref_mem[int];

  function automatic logic [31:0] ref_word(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // MCB model: write FIFO buffer, memory array, first-word-fall-through read FIFO
  logic [31:0] mcb_mem[int];
  logic [35:0] mwq[$];
  logic [31:0] rdq[$];
  bit   starve = 0, wfull_rand = 0, cfull_rand = 0, cfull_force = 0, rd_tog = 0;
  int   rd_mode = 0;
  bit   s_pop, s_cmd;
  cmd_t s_c;

  always @(negedge clk) begin
    s_pop = mcb_rd_en;
    s_cmd = cmd_en;
    s_c   = {cmd_instr, cmd_bl, cmd_byte_addr};
    if (mcb_wr_en) mwq.push_back({mcb_wr_mask, mcb_wr_data});
  end

  always @(posedge clk) begin
    #2;
    if (s_pop && rdq.size() > 0) void'(rdq.pop_front());
    if (s_cmd) begin
      int base;
      base = int'(s_c.ba >> 2);
      for (int i = 0; i <= int'(s_c.bl); i++) begin
        if (s_c.instr == MCB_WRITE) begin
          if (mwq.size() > 0) begin
            logic [35:0] w;
            logic [31:0] old;
            w   = mwq.pop_front();
            old = mcb_mem.exists(base + i) ? mcb_mem[base + i] : init_word(base + i);
            mcb_mem[base + i] = merge(old, w[31:0], ~w[35:32]);
          end
        end else if (!starve) begin
          rdq.push_back(mcb_mem.exists(base + i) ? mcb_mem[base + i] : init_word(base + i));
        end
      end
      s_cmd = 0;
    end
    mcb_rd_empty = (rdq.size() == 0);
    mcb_rd_data  = (rdq.size() == 0) ? 32'h0 : rdq[0];
    rd_tog       = ~rd_tog;
    rd_ready     = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? rd_tog : ($urandom_range(3) != 0);
    mcb_wr_full  = wfull_rand && ($urandom_range(3) == 0);
    cmd_full     = cfull_force || (cfull_rand && $urandom_range(4) == 0);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction
  int cyc = 0, cmd_cnt = 0, pop_cnt = 0, push_cnt = 0, last_cmd_cyc = 0, last_done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mcb_wr_en) begin
      push_cnt++;
      if (exp_wr.size() == 0) check_eq("unexpected_wr_push", mcb_wr_en, 0);
      else begin
        logic [35:0] e;
        e = exp_wr.pop_front();
        check_eq("wr_push", {mcb_wr_mask, mcb_wr_data}, e);
        $display("push  data=%08h mask=%h", mcb_wr_data, mcb_wr_mask);
      end
    end
    if (mcb_rd_en) pop_cnt++;
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) check_eq("unexpected_rd_word", rd_valid, 0);
      else begin
        logic [31:0] e;
        e = exp_rd.pop_front();
        check_eq("rd_data", rd_data, e);
        $display("read  data=%08h", rd_data);
      end
    end
    if (cmd_en) begin
      cmd_cnt++;
      last_cmd_cyc = cyc;
      check_eq("done_with_cmd_en", done, 0);
      if (exp_cmd.size() == 0) check_eq("unexpected_cmd", cmd_en, 0);
      else begin
        cmd_t e;
        e = exp_cmd.pop_front();
        check_eq("cmd", {cmd_instr, cmd_bl, cmd_byte_addr}, e);
        $display("cmd   instr=%0d bl=%0d byte_addr=%08h", cmd_instr, cmd_bl, cmd_byte_addr);
      end
    end
    if (done) begin
      last_done_cyc = cyc;
      check_eq("rd_words_before_done", exp_rd.size(), 0);
      if (exp_done.size() == 0) check_eq("unexpected_done", done, 0);
      else begin
        bit e;
        e = exp_done.pop_front();
        check_eq("done_err", err, e);
        $display("done  err=%0d err_sticky=%0d", err, err_sticky);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input int a, input int l, output int waited);
    req_valid = 1; req_write = wr; req_addr = AW'(a); req_len = 6'(l);
    for (waited = 0; waited <= 500; waited++) begin
      @(negedge clk);
      if (req_ready) break;
      step();
    end
    if (waited > 500) check_eq("req_accept_timeout", req_ready, 1);
    step();
    req_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check_eq("done_seen", done, 1);
    step();
  endtask

  task automatic push_cmd(input logic [2:0] instr, input int a, input int l);
    cmd_t c;
    c.instr = instr; c.bl = 6'(l); c.ba = 30'(a) * 30'd4;
    exp_cmd.push_back(c);
  endtask

  task automatic write_burst(input int a, input int l, input bit fixed, input bit inject,
                             output int waited);
    logic [31:0] d[64];
    logic [3:0]  be[64];
    int i, g;
    for (int k = 0; k < 64; k++) begin
      d[k]  = fixed ? 32'hA0 + 32'(k) : $urandom;
      be[k] = fixed ? 4'hF : 4'($urandom_range(15));
    end
    push_cmd(MCB_WRITE, a, l);
    for (int k = 0; k <= l; k++) begin
      exp_wr.push_back({~be[k], d[k]});
      ref_mem[a + k] = merge(ref_word(a + k), d[k], be[k]);
    end
    exp_done.push_back(inject);
    issue(1, a, l, waited);
    i = 0; g = 0;
    while (i <= l && g < 1000) begin
      wr_valid = ($urandom_range(3) != 0);
      wr_data = d[i]; wr_be = be[i];
      mcb_wr_error = inject && (g == 2);
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      step();
      g++;
    end
    wr_valid = 0; mcb_wr_error = 0;
    check_eq("wr_fill_progress", i, l + 1);
    wait_done();
  endtask

  task automatic read_burst(input int a, input int l);
    int w;
    push_cmd(MCB_READ, a, l);
    for (int k = 0; k <= l; k++) exp_rd.push_back(ref_word(a + k));
    exp_done.push_back(0);
    issue(0, a, l, w);
    wait_done();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c0, p0, q0;
    rst_n = 0; calibration_done = 1; req_valid = 0; req_write = 0; req_addr = '0;
    req_len = '0; wr_valid = 0; wr_data = '0; wr_be = '0;
    mcb_wr_underrun = 0; mcb_wr_error = 0; mcb_rd_overflow = 0; mcb_rd_error = 0;
    repeat (3) step();
    @(negedge clk);
    check_eq("reset_outputs", all_outs, 0);
    step(); rst_n = 1; calibration_done = 0;
    @(negedge clk);
    check_eq("idle_outputs", all_outs, 0);
    step();

    // Calibration gate: request held, nothing may happen until calibration_done
    req_valid = 1; req_write = 1; req_addr = AW'(32'h100); req_len = 6'd3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("uncal_req_ready", req_ready, 0);
      check_eq("uncal_activity", {busy, cmd_en, mcb_wr_en, mcb_rd_en}, 0);
      step();
    end
    calibration_done = 1;

    // Directed write: 0xA0..0xA3 at word 0x100
    c0 = cmd_cnt; q0 = push_cnt;
    write_burst(32'h100, 3, 1, 0, w);
    check_eq("cal_accept_wait", w, 0);
    check_eq("write_cmd_count", cmd_cnt - c0, 1);
    check_eq("write_push_count", push_cnt - q0, 4);

    // Directed read of 64 words with rd_ready toggling
    rd_mode = 1; p0 = pop_cnt;
    read_burst(0, 63);
    check_eq("read64_pop_count", pop_cnt - p0, 64);
    rd_mode = 0;

    // Command FIFO full for 20 cycles during RD_CMD
    cfull_force = 1;
    c0 = cmd_cnt;
    push_cmd(MCB_READ, 32'h100, 3);
    for (int k = 0; k <= 3; k++) exp_rd.push_back(ref_word(32'h100 + k));
    exp_done.push_back(0);
    issue(0, 32'h100, 3, w);
    repeat (20) step();
    check_eq("cmd_held_by_full", cmd_cnt - c0, 0);
    check_eq("busy_while_stalled", busy, 1);
    cfull_force = 0;
    @(negedge clk);
    check_eq("cmd_en_before_release", cmd_en, 0);
    step();
    @(negedge clk);
    check_eq("cmd_en_first_free_cycle", cmd_en, 1);
    wait_done();
    check_eq("stall_cmd_count", cmd_cnt - c0, 1);
    check_eq("sticky_clean", err_sticky, 0);

    // Status error during a write is reported but the burst completes
    write_burst(32'h200, 3, 0, 1, w);
    check_eq("sticky_after_wr_error", err_sticky, 1);
    write_burst(32'h210, 2, 0, 0, w);
    check_eq("sticky_holds", err_sticky, 1);

    // Read timeout: model never supplies data
    starve = 1;
    push_cmd(MCB_READ, 32'h40, 0);
    exp_done.push_back(1);
    issue(0, 32'h40, 0, w);
    wait_done();
    check_eq("timeout_latency", last_done_cyc - last_cmd_cyc, TMO + 1);
    check_eq("sticky_after_timeout", err_sticky, 1);
    starve = 0;

    // Randomized mixed bursts under random back-pressure
    wfull_rand = 1; cfull_rand = 1; rd_mode = 2;
    for (int t = 0; t < 24; t++) begin
      int a, l;
      a = $urandom_range(255);
      l = ($urandom_range(7) == 0) ? $urandom_range(63) : $urandom_range(15);
      if ($urandom_range(1) == 1) write_burst(a, l, 0, 0, w);
      else read_burst(a, l);
    end
    wfull_rand = 0; cfull_rand = 0; rd_mode = 0;

    // Reset mid WR_FILL after two of eight pushes
    for (int k = 0; k < 8; k++) exp_wr.push_back({4'h0, 32'hD0 + 32'(k)});
    issue(1, 32'h300, 7, w);
    begin
      int n, g;
      n = 0; g = 0;
      while (n < 2 && g < 100) begin
        wr_valid = 1; wr_be = 4'hF; wr_data = 32'hD0 + 32'(n);
        @(negedge clk);
        if (wr_valid && wr_ready) n++;
        step();
        g++;
      end
      check_eq("pushes_before_reset", n, 2);
    end
    rst_n = 0; wr_valid = 0;
    step();
    wr_valid = 1; req_valid = 1;
    @(negedge clk);
    check_eq("outputs_after_reset", all_outs, 0);
    step();
    @(negedge clk);
    check_eq("outputs_in_reset", all_outs, 0);
    step();
    wr_valid = 0; req_valid = 0;
    exp_wr.delete(); mwq.delete();
    rst_n = 1; c0 = cmd_cnt;
    repeat (30) step();
    check_eq("no_cmd_after_reset", cmd_cnt - c0, 0);
    check_eq("sticky_cleared_by_reset", err_sticky, 0);
    check_eq("idle_after_reset", busy, 0);

    check_eq("sb_cmd_left", exp_cmd.size(), 0);
    check_eq("sb_rd_left", exp_rd.size(), 0);
    check_eq("sb_done_left", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
